// File: rtl/spi_drain_scheduler.sv
// Drain scheduler between the sample FIFO and the SPI master feeding the MBED uC.
// Optional FIFO-level auto-drain is enabled by defining SPI_DRAIN_WATERMARK_EN.
module spi_drain_scheduler #(
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic             SYS_CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             TICK,
    input  logic             MAN_REQ,
    input  logic             FIFO_EMPTY,
    input  logic             FIFO_FULL,
    input  logic             SPI_FIN,
`ifdef SPI_DRAIN_WATERMARK_EN
    input  logic [8:0]       FIFO_USEDW,
    input  logic [8:0]       WMARK,
`endif
    output logic             SPI_ENA,
    output logic             FIFO_RD,
    output logic             BUSY,
    output logic             OVF,
    output logic             ERR,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [1:0]       DBG_STATE
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] BURST = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        POP  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [7:0]       remaining;
    logic             pending;
    logic             fin_q;
    logic             full_q;

    logic req;
    logic start;
    logic fin_rise;
    logic full_rise;

    assign req       = TICK | MAN_REQ;
    assign fin_rise  = SPI_FIN & ~fin_q;
    assign full_rise = FIFO_FULL & ~full_q;

`ifdef SPI_DRAIN_WATERMARK_EN
    // A FIFO at or above the watermark behaves like a fresh request while idle.
    assign start = req | pending | ((WMARK != 9'd0) && (FIFO_USEDW >= WMARK));
`else
    assign start = req | pending;
`endif

    assign BUSY      = (state != IDLE);
    assign DBG_STATE = state;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            pending   <= 1'b0;
            fin_q     <= 1'b0;
            full_q    <= 1'b0;
            SPI_ENA   <= 1'b0;
            FIFO_RD   <= 1'b0;
            OVF       <= 1'b0;
            ERR       <= 1'b0;
            WORD_CNT  <= '0;
        end else begin
            fin_q   <= SPI_FIN;
            full_q  <= FIFO_FULL;
            FIFO_RD <= 1'b0;

            if (full_rise)
                OVF <= 1'b1;
            else if (CLR)
                OVF <= 1'b0;

            // Cleared here first so a timeout in the same cycle still sets it.
            if (CLR)
                ERR <= 1'b0;

            // Requests arriving mid-burst collapse into one pending slot.
            if (req)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (start && !FIFO_EMPTY) begin
                        state     <= XFER;
                        SPI_ENA   <= 1'b1;
                        timer     <= '0;
                        remaining <= BURST;
                    end
                end
                XFER: begin
                    if (fin_rise) begin
                        state   <= POP;
                        SPI_ENA <= 1'b0;
                        FIFO_RD <= 1'b1;
                    end else if (timer == TMR_LAST) begin
                        state   <= IDLE;
                        SPI_ENA <= 1'b0;
                        ERR     <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                POP: begin
                    WORD_CNT  <= WORD_CNT + CNT_W'(1);
                    remaining <= remaining - 8'd1;
                    timer     <= '0;
                    state     <= GAP;
                end
                GAP: begin
                    // FIFO_EMPTY here is at least one cycle past the pop.
                    if (!SPI_FIN) begin
                        if (remaining != 8'd0 && !FIFO_EMPTY) begin
                            state   <= XFER;
                            SPI_ENA <= 1'b1;
                            timer   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timer == TMR_LAST) begin
                        state <= IDLE;
                        ERR   <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (CLR)
                WORD_CNT <= '0;
        end
    end

endmodule

// File: tb/tb_spi_drain_scheduler.sv
// Self-checking bench for spi_drain_scheduler: FIFO/SPI behavioural models,
// a WORD_CNT scoreboard fed at stimulus time, vector table plus corner sequences.
module tb_spi_drain_scheduler;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             tick;
    logic             man_req;
    logic             fifo_empty;
    logic             full_drv;
    logic             spi_fin;
    logic             spi_ena;
    logic             fifo_rd;
    logic             busy;
    logic             ovf;
    logic             err;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       dbg_state;
`ifdef SPI_DRAIN_WATERMARK_EN
    logic [8:0]       fifo_usedw;
    logic [8:0]       wmark;
`endif

    int               fifo_cnt = 0;
    int               load_val;
    logic             load_en;
    logic             fin_mute;
    int               ena_cnt = 0;

    int               n_cmp = 0;
    int               n_err = 0;
    int               pop_cnt = 0;
    logic             chk_next = 1'b0;
    logic [CNT_W-1:0] exp_wc = '0;
    logic [CNT_W-1:0] exp_q[$];

    typedef struct {
        int   add;
        logic tick;
        logic man;
        int   exp_pops;
        int   exp_left;
    } vec_t;
    vec_t vecs[7];

    spi_drain_scheduler #(.BURST_LEN(4), .TIMEOUT_CYC(4096), .CNT_W(CNT_W)) dut (
        .SYS_CLK    (clk),
        .RST        (rst),
        .CLR        (clr),
        .TICK       (tick),
        .MAN_REQ    (man_req),
        .FIFO_EMPTY (fifo_empty),
        .FIFO_FULL  (full_drv),
        .SPI_FIN    (spi_fin),
`ifdef SPI_DRAIN_WATERMARK_EN
        .FIFO_USEDW (fifo_usedw),
        .WMARK      (wmark),
`endif
        .SPI_ENA    (spi_ena),
        .FIFO_RD    (fifo_rd),
        .BUSY       (busy),
        .OVF        (ovf),
        .ERR        (err),
        .WORD_CNT   (word_cnt),
        .DBG_STATE  (dbg_state)
    );

    // ---------------- clock / models ----------------
    always #10 clk = ~clk;

    assign fifo_empty = (fifo_cnt == 0);
`ifdef SPI_DRAIN_WATERMARK_EN
    assign fifo_usedw = 9'(fifo_cnt);
`endif

    always @(posedge clk) begin
        if (load_en)
            fifo_cnt <= load_val;
        else if (fifo_rd && fifo_cnt > 0)
            fifo_cnt <= fifo_cnt - 1;
    end

    // SPI master: raises FIN 20 cycles into an enable, drops it when ENA drops.
    always @(posedge clk) begin
        if (!spi_ena) begin
            ena_cnt <= 0;
            spi_fin <= 1'b0;
        end else if (!fin_mute) begin
            ena_cnt <= ena_cnt + 1;
            if (ena_cnt == 19)
                spi_fin <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_wc = exp_wc + CNT_W'(1);
            exp_q.push_back(exp_wc);
        end
    endtask

    // Scoreboard monitor: each pop must hit a non-empty FIFO and bump WORD_CNT.
    always @(negedge clk) begin
        if (rst) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk_next = 1'b0;
                if (exp_q.size() == 0)
                    check("unexpected_pop", 1, 0);
                else
                    check("word_cnt", int'(word_cnt), int'(exp_q.pop_front()));
            end
            if (fifo_rd) begin
                pop_cnt++;
                chk_next = 1'b1;
                check("rd_while_empty", int'(fifo_empty), 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input int n);
        @(negedge clk);
        load_val = n;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic pulse_req(input logic t, input logic m);
        @(negedge clk);
        tick    = t;
        man_req = m;
        @(negedge clk);
        tick    = 1'b0;
        man_req = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (i == max) check({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_pops(input int target, input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            if (pop_cnt >= target) break;
            @(negedge clk);
        end
        if (i == max) check({name, "_pop_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int base;
        int cnt;
        rst      = 1'b1;
        clr      = 1'b0;
        tick     = 1'b0;
        man_req  = 1'b0;
        full_drv = 1'b0;
        fin_mute = 1'b0;
        load_en  = 1'b0;
        load_val = 0;
`ifdef SPI_DRAIN_WATERMARK_EN
        wmark    = 9'd0;
`endif
        vecs[0] = '{6, 1'b1, 1'b0, 4, 2};
        vecs[1] = '{0, 1'b1, 1'b0, 2, 0};
        vecs[2] = '{0, 1'b1, 1'b0, 0, 0};
        vecs[3] = '{1, 1'b1, 1'b1, 1, 0};
        vecs[4] = '{3, 1'b0, 1'b1, 3, 0};
        vecs[5] = '{5, 1'b0, 1'b1, 4, 1};
        vecs[6] = '{0, 1'b1, 1'b0, 1, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_spi_ena", int'(spi_ena), 0);
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_err", int'(err), 0);
        check("rst_word_cnt", int'(word_cnt), 0);

        // Vector table: burst length, early end on empty, dropped and merged requests.
        foreach (vecs[k]) begin
            if (vecs[k].add != 0) load(fifo_cnt + vecs[k].add);
            base = pop_cnt;
            push_exp(vecs[k].exp_pops);
            pulse_req(vecs[k].tick, vecs[k].man);
            check($sformatf("v%0d_ena_latency", k), int'(spi_ena), int'(vecs[k].exp_pops > 0));
            wait_idle(1000, $sformatf("v%0d", k));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_no_pending", k), int'(busy), 0);
            check($sformatf("v%0d_pops", k), pop_cnt - base, vecs[k].exp_pops);
            check($sformatf("v%0d_fifo_left", k), fifo_cnt, vecs[k].exp_left);
        end

        // Request during a burst is held and replayed right after the burst.
        load(8);
        base = pop_cnt;
        push_exp(8);
        pulse_req(1'b1, 1'b0);
        wait_pops(base + 1, 200, "pend");
        pulse_req(1'b0, 1'b1);
        wait_pops(base + 4, 500, "pend");
        wait_idle(50, "pend_gap");
        cnt = 0;
        while (!spi_ena && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("pend_restart_within_2", int'(cnt >= 1 && cnt <= 2), 1);
        wait_pops(base + 8, 500, "pend2");
        wait_idle(50, "pend2");
        check("pend_total_pops", pop_cnt - base, 8);
        check("pend_fifo_left", fifo_cnt, 0);

        // Asynchronous reset in the middle of a transfer.
        load(3);
        pulse_req(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("rst_mid_ena_before", int'(spi_ena), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ena", int'(spi_ena), 0);
        check("rst_mid_word_cnt", int'(word_cnt), 0);
        check("rst_mid_busy", int'(busy), 0);
        exp_q.delete();
        exp_wc = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_stays_idle", int'(busy), 0);

        // Timeout: the SPI master never answers.
        load(2);
        fin_mute = 1'b1;
        base = pop_cnt;
        pulse_req(1'b1, 1'b0);
        cnt = 0;
        while (spi_ena && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_ena_cycles", cnt, 4096);
        check("tmo_err", int'(err), 1);
        check("tmo_busy", int'(busy), 0);
        check("tmo_no_pop", pop_cnt - base, 0);
        check("tmo_fifo_kept", fifo_cnt, 2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_wc = '0;
        check("tmo_clr_err", int'(err), 0);
        check("tmo_clr_word_cnt", int'(word_cnt), 0);
        fin_mute = 1'b0;
        load(0);

        // Overflow flag: sticky, and a coincident set beats CLR.
        full_drv = 1'b1;
        @(negedge clk);
        check("ovf_set", int'(ovf), 1);
        full_drv = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_hold", int'(ovf), 1);
        full_drv = 1'b1;
        clr      = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_set_beats_clr", int'(ovf), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_clr", int'(ovf), 0);
        full_drv = 1'b0;

`ifdef SPI_DRAIN_WATERMARK_EN
        // Watermark crossing starts a burst on its own.
        wmark = 9'd8;
        load(7);
        repeat (3) @(negedge clk);
        check("wm_below", int'(busy), 0);
        base = pop_cnt;
        push_exp(4);
        load(8);
        cnt = 0;
        while (!busy && cnt < 5) begin
            @(negedge clk);
            cnt++;
        end
        check("wm_started", int'(busy), 1);
        wait_idle(500, "wm");
        repeat (3) @(negedge clk);
        check("wm_pops", pop_cnt - base, 4);
        check("wm_fifo_left", fifo_cnt, 4);
        wmark = 9'd0;
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_drain_scheduler.md
Name: spi_drain_scheduler

Overview:
Controller that sequences draining of the sample FIFO into the SPI master feeding the MBED microcontroller. Replaces the ad-hoc enable logic at top level with an explicit FSM. The FSM accepts periodic and manual drain requests, runs bursts of word transfers, pops the FIFO on each completed transfer, and latches FIFO overflow so the sample counter can be halted. Sits between FIFO_IP and SPI_MASTER_UC, on the 40 MHz system clock.

Parameters:
BURST_LEN, 4, maximum words transferred per accepted request (1..255)
TIMEOUT_CYC, 4096, SYS_CLK cycles allowed for an SPI_FIN rising edge (or SPI_FIN low in GAP) before abort
CNT_W, 16, width of the transferred-word counter

Ports:
SYS_CLK  in  1  system clock (40 MHz)
RST  in  1  asynchronous reset, active-high
CLR  in  1  synchronous clear of OVF, ERR and WORD_CNT; FSM unaffected
TICK  in  1  one-cycle periodic drain request
MAN_REQ  in  1  one-cycle manual drain request (already edge-detected)
FIFO_EMPTY  in  1  FIFO empty flag
FIFO_FULL  in  1  FIFO full flag
SPI_FIN  in  1  SPI master transfer-finished level
SPI_ENA  out  1  SPI master enable
FIFO_RD  out  1  one-cycle FIFO read request (pop)
BUSY  out  1  high in any state other than IDLE
OVF  out  1  sticky: a FIFO_FULL rising edge has been seen
ERR  out  1  sticky: a transfer has timed out
WORD_CNT  out  CNT_W  count of words popped after successful transfers

Behaviour:
- Reset: state=IDLE; SPI_ENA=0, FIFO_RD=0, BUSY=0, OVF=0, ERR=0, WORD_CNT=0; pending=0; internal FIN/FULL history regs=0.
- req = TICK | MAN_REQ. TICK and MAN_REQ asserted in the same cycle count as one request.
- IDLE: if (req | pending) & ~FIFO_EMPTY -> XFER; remaining=BURST_LEN; pending cleared. If req & FIFO_EMPTY, the request is dropped.
- XFER: SPI_ENA=1; timer counts. On an SPI_FIN rising edge (registered previous value) -> POP. If timer reaches TIMEOUT_CYC-1 -> ERR=1, SPI_ENA=0 next cycle, no pop, go to IDLE.
- POP: SPI_ENA=0, FIFO_RD=1 for exactly this cycle; WORD_CNT+1 (wraps modulo 2^CNT_W); remaining-1 -> GAP.
- GAP: SPI_ENA=0; wait for SPI_FIN=0 (timeout as in XFER sets ERR and goes to IDLE). When SPI_FIN=0: if remaining>0 & ~FIFO_EMPTY -> XFER (timer reset), otherwise -> IDLE. FIFO_EMPTY is sampled at least one cycle after FIFO_RD, which covers the FIFO flag update latency.
- Latency: request to SPI_ENA high = 1 cycle. SPI_FIN edge to FIFO_RD = 1 cycle after edge detection.
- req while BUSY sets pending (one deep; further requests merge). Pending is serviced on return to IDLE.
- OVF is set on a FIFO_FULL 0->1 transition and held until CLR or RST. The top level uses OVF to halt sampling.
- CLR coincident with an OVF-set or ERR-set event: the set wins. CLR coincident with a WORD_CNT increment: WORD_CNT=0.
- Async RST mid-transfer: SPI_ENA drops immediately, with no pop.
- FIFO_RD is never asserted while FIFO_EMPTY=1.

Optional Feature:
SPI_DRAIN_WATERMARK_EN
- With the macro: adds inputs FIFO_USEDW (9 bits) and WMARK (9 bits). In IDLE, FIFO_USEDW >= WMARK (with WMARK != 0) acts as an extra req, so the FIFO drains automatically before overflow. Overflow, ERR and pending behaviour are unchanged.
- Without the macro: the ports are absent, and only TICK and MAN_REQ generate requests.

Test Plan:
- FIFO holds 6 words, BURST_LEN=4, one TICK; FIN model pulses 20 cycles after ENA -> 4 FIFO_RD pulses, WORD_CNT=4, return to IDLE. Second TICK -> 2 pops, WORD_CNT=6, FIFO_EMPTY ends burst early.
- TICK while FIFO_EMPTY=1 -> SPI_ENA stays 0, BUSY stays 0, no pending. TICK and MAN_REQ together with 1 word -> exactly 1 pop.
- FIN model never responds, TIMEOUT_CYC=4096 -> ERR=1 at cycle 4096 of XFER, SPI_ENA=0, FIFO_RD never asserted, FSM in IDLE; CLR -> ERR=0.
- MAN_REQ during burst 2 of 4 -> after burst ends, a new burst starts within 2 cycles without a new request.
- FIFO_FULL rising -> OVF=1 and held after FULL falls; CLR in the same cycle as a second FULL rise -> OVF stays 1.
- RST asserted mid-XFER -> SPI_ENA=0 asynchronously, WORD_CNT=0. With SPI_DRAIN_WATERMARK_EN, WMARK=8 and USEDW 7->8 -> burst starts with no TICK.
